// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding and requester IDs.
package dmem_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_t;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_LDR = 1'b1;

  // Wide enough for the largest supported MAX_WAIT (15).
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, read-return and RAM-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              lock1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, ram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata
  );

  modport mem (
    input  ram_en, ram_we, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/dmem_rd_tag_pipe.sv
// Valid+ID shift register that follows each RAM read until its data emerges.
module dmem_rd_tag_pipe #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_id,
  output logic out_valid,
  output logic out_id
);

  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] id_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      id_reg    <= '0;
    end else begin
      valid_reg <= {valid_reg[STAGES-2:0], in_valid};
      id_reg    <= {id_reg[STAGES-2:0], in_id};
    end
  end

  assign out_valid = valid_reg[STAGES-1];
  assign out_id    = id_reg[STAGES-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU data port vs. loader) in front of one single-port RAM,
// with loader starvation limit, loader burst lock and pipelined read return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

  arb_state_t            state_reg;
  logic [WAIT_CNT_W-1:0] wait_cnt_reg;
  logic                  ram_en_reg;
  logic                  ram_we_reg;
  logic                  ram_id_reg;
  logic [ADDR_W-1:0]     ram_addr_reg;
  logic [DATA_W-1:0]     ram_din_reg;

  logic ldr_turn;
  logic gnt0;
  logic gnt1;
  logic acc0;
  logic acc1;
  logic tag_valid;
  logic tag_id;

  // The loader only pre-empts the CPU once it has waited MAX_WAIT cycles and still asks.
  always_comb begin
    ldr_turn = (wait_cnt_reg == MAX_WAIT_C);
    gnt0     = !reset && (state_reg == ARB) && bus.req0 && !(ldr_turn && bus.req1);
    gnt1     = !reset && bus.req1 && ((state_reg == LOCK1) || !bus.req0 || ldr_turn);
    acc0     = bus.req0 && gnt0;
    acc1     = bus.req1 && gnt1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ARB;
      wait_cnt_reg <= '0;
      ram_en_reg   <= 1'b0;
      ram_we_reg   <= 1'b0;
      ram_id_reg   <= ID_CPU;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
    end else begin
      ram_en_reg <= acc0 || acc1;
      ram_we_reg <= (acc0 && bus.we0) || (acc1 && bus.we1);
      if (acc0) begin
        ram_addr_reg <= bus.addr0;
        ram_din_reg  <= bus.wdata0;
        ram_id_reg   <= ID_CPU;
      end else if (acc1) begin
        ram_addr_reg <= bus.addr1;
        ram_din_reg  <= bus.wdata1;
        ram_id_reg   <= ID_LDR;
      end

      case (state_reg)
        ARB: begin
          if (acc1 && bus.lock1) begin
            state_reg <= LOCK1;
          end
          if (acc1 || !bus.req1) begin
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg != MAX_WAIT_C) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        LOCK1: begin
          wait_cnt_reg <= '0;
          if (!bus.req1 || (acc1 && !bus.lock1)) begin
            state_reg <= ARB;
          end
        end
        default: state_reg <= ARB;
      endcase
    end
  end

  // Tags are launched from the registered RAM command, so they line up with ram_dout.
  dmem_rd_tag_pipe #(
    .STAGES (2)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (ram_en_reg && !ram_we_reg),
    .in_id     (ram_id_reg),
    .out_valid (tag_valid),
    .out_id    (tag_id)
  );

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rvalid0  = tag_valid && (tag_id == ID_CPU);
  assign bus.rvalid1  = tag_valid && (tag_id == ID_LDR);
  assign bus.rdata    = bus.ram_dout;
  assign bus.ram_en   = ram_en_reg;
  assign bus.ram_we   = ram_we_reg;
  assign bus.ram_addr = ram_addr_reg;
  assign bus.ram_din  = ram_din_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-output single-port RAM model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .MAX_WAIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM samples on one edge and presents the word on the next.
  logic [31:0] mem [256];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      else            ram_q <= mem[bus.ram_addr];
    end
    bus.ram_dout <= ram_q;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0;
  endtask

  task automatic cpu(input logic we, input logic [7:0] addr, input logic [31:0] data);
    bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = data;
  endtask

  task automatic ldr(input logic we, input logic [7:0] addr, input logic [31:0] data,
                     input logic lock);
    bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = data; bus.lock1 = lock;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle();
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    reset = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    repeat (2) tick();
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_ram_en", bus.ram_en, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_din", bus.ram_din, 0);
    check("rst_rvalid0", bus.rvalid0, 0);
    check("rst_state", dut.state_reg, ARB);
    idle();
    reset = 1'b0;
    tick();

    // Single CPU read of a freshly written word
    cpu(1'b1, 8'h10, 32'hDEADBEEF);
    #1 check("wr16_gnt0", bus.gnt0, 1);
    check("wr16_gnt1", bus.gnt1, 0);
    tick();
    check("wr16_ram_we", bus.ram_we, 1);
    check("wr16_ram_addr", bus.ram_addr, 8'h10);
    check("wr16_ram_din", bus.ram_din, 32'hDEADBEEF);
    cpu(1'b0, 8'h10, 32'h0);
    #1 check("rd16_gnt0", bus.gnt0, 1);
    tick();
    check("rd16_ram_en", bus.ram_en, 1);
    check("rd16_ram_we", bus.ram_we, 0);
    idle();
    tick();
    check("rd16_early", bus.rvalid0, 0);
    check("rd16_noen", bus.ram_en, 0);
    tick();
    check("rd16_rvalid0", bus.rvalid0, 1);
    check("rd16_rvalid1", bus.rvalid1, 0);
    check("rd16_rdata", bus.rdata, 32'hDEADBEEF);
    tick();
    check("rd16_once", bus.rvalid0, 0);

    // Write then read the same address on consecutive edges
    cpu(1'b1, 8'h05, 32'h12345678);
    tick();
    cpu(1'b0, 8'h05, 32'h0);
    tick();
    idle();
    tick();
    check("wr_rd_early", bus.rvalid0, 0);
    tick();
    check("wr_rd_rvalid0", bus.rvalid0, 1);
    check("wr_rd_rdata", bus.rdata, 32'h12345678);
    tick();

    // Pipelined CPU / loader / CPU reads
    cpu(1'b0, 8'h10, 32'h0);
    #1 check("mix_a_gnt0", bus.gnt0, 1);
    tick();
    idle();
    ldr(1'b0, 8'h05, 32'h0, 1'b0);
    #1 check("mix_b_gnt1", bus.gnt1, 1);
    check("mix_b_gnt0", bus.gnt0, 0);
    tick();
    idle();
    cpu(1'b0, 8'h10, 32'h0);
    #1 check("mix_c_gnt0", bus.gnt0, 1);
    tick();
    check("mix_a_rvalid0", bus.rvalid0, 1);
    check("mix_a_rvalid1", bus.rvalid1, 0);
    check("mix_a_rdata", bus.rdata, 32'hDEADBEEF);
    idle();
    tick();
    check("mix_b_rvalid1", bus.rvalid1, 1);
    check("mix_b_rvalid0", bus.rvalid0, 0);
    check("mix_b_rdata", bus.rdata, 32'h12345678);
    tick();
    check("mix_c_rvalid0", bus.rvalid0, 1);
    check("mix_c_rdata", bus.rdata, 32'hDEADBEEF);
    tick();
    check("mix_end_rv0", bus.rvalid0, 0);
    check("mix_end_rv1", bus.rvalid1, 0);

    // Contention: 4 CPU grants then 1 loader grant, repeating
    cpu(1'b1, 8'h30, 32'hAAAA0000);
    ldr(1'b1, 8'h31, 32'h5555FFFF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1 check($sformatf("cont%0d_gnt0", i), bus.gnt0, (i % 5 == 4) ? 0 : 1);
      check($sformatf("cont%0d_gnt1", i), bus.gnt1, (i % 5 == 4) ? 1 : 0);
      tick();
    end
    idle();
    tick();

    // Loader burst lock holds the CPU off until lock1 drops
    ldr(1'b1, 8'h50, 32'h00000050, 1'b1);
    #1 check("lock1_gnt1", bus.gnt1, 1);
    check("lock1_gnt0", bus.gnt0, 0);
    tick();
    cpu(1'b1, 8'h40, 32'h00000040);
    ldr(1'b1, 8'h51, 32'h00000051, 1'b1);
    #1 check("lock2_gnt0", bus.gnt0, 0);
    check("lock2_gnt1", bus.gnt1, 1);
    tick();
    ldr(1'b1, 8'h52, 32'h00000052, 1'b0);
    #1 check("lock3_gnt0", bus.gnt0, 0);
    check("lock3_gnt1", bus.gnt1, 1);
    tick();
    check("lock3_ram_addr", bus.ram_addr, 8'h52);
    bus.req1 = 1'b0;
    bus.lock1 = 1'b0;
    #1 check("unlock_gnt0", bus.gnt0, 1);
    check("unlock_gnt1", bus.gnt1, 0);
    tick();
    check("unlock_ram_addr", bus.ram_addr, 8'h40);
    idle();
    tick();

    // Reset one cycle after a read acceptance, while in LOCK1
    cpu(1'b0, 8'h10, 32'h0);
    tick();
    idle();
    ldr(1'b1, 8'h60, 32'h00000060, 1'b1);
    tick();
    check("prerst_state", dut.state_reg, LOCK1);
    idle();
    reset = 1'b1;
    #1 check("midrst_ram_en", bus.ram_en, 0);
    check("midrst_state", dut.state_reg, ARB);
    check("midrst_rvalid0", bus.rvalid0, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("postrst%0d_rvalid0", i), bus.rvalid0, 0);
      check($sformatf("postrst%0d_rvalid1", i), bus.rvalid1, 0);
      check($sformatf("postrst%0d_ram_en", i), bus.ram_en, 0);
    end
    check("postrst_state", dut.state_reg, ARB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, the loader wait-cycle limit that forces a loader grant (range 1-15).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have ports req0/req1, input, 1, access request (0 = CPU data port, 1 = loader).
REQ-007 SHALL have ports we0/we1, input, 1, write (1) or read (0).
REQ-008 SHALL have ports addr0/addr1, input, ADDR_W, word address.
REQ-009 SHALL have ports wdata0/wdata1, input, DATA_W, write data.
REQ-010 SHALL have port lock1, input, 1, loader burst hold.
REQ-011 SHALL have ports gnt0/gnt1, output, 1, combinational accept.
REQ-012 SHALL have ports rvalid0/rvalid1, output, 1, read data valid.
REQ-013 SHALL have port rdata, output, DATA_W, read data shared by both requesters.
REQ-014 SHALL have ports ram_en, ram_we, ram_addr, ram_din, output, to the single-port RAM.
REQ-015 SHALL have port ram_dout, input, DATA_W, RAM read data, valid one edge after the RAM samples.

Function
REQ-016 SHALL accept a request when reqN and gntN are both high at a rising edge; at most one gnt is high per cycle.
REQ-017 SHALL register ram_en/ram_we/ram_addr/ram_din from the accepted request at the acceptance edge.
- With no acceptance, ram_en and ram_we are 0.
- ram_addr and ram_din hold their values.
REQ-018 SHALL return reads as follows:
- rvalidN is high for exactly one cycle, starting two edges after acceptance.
- rdata equals ram_dout during that cycle.
- Writes produce no rvalid.
REQ-019 SHALL sustain one acceptance per cycle; back-to-back reads from either requester pipeline without bubbles, returning in acceptance order.
REQ-020 SHALL implement FSM states ARB and LOCK1.
REQ-021 In ARB, SHALL grant as follows:
- CPU wins when wait_cnt < MAX_WAIT.
- Loader wins when req0 is low, or when wait_cnt == MAX_WAIT.
REQ-022 SHALL handle wait_cnt as follows:
- Increment wait_cnt when req1 is high and not accepted.
- Saturate at MAX_WAIT.
- Clear to 0 on any loader acceptance or when req1 is low.
REQ-023 SHALL transition ARB -> LOCK1 on a loader acceptance with lock1 high.
REQ-024 In LOCK1, SHALL never assert gnt0, and SHALL assert gnt1 whenever req1 is high.
REQ-025 SHALL transition LOCK1 -> ARB in either case:
- A loader acceptance with lock1 low.
- Any cycle with req1 low.
REQ-026 SHALL hold wait_cnt at 0 in LOCK1.
REQ-027 SHALL not drop or reorder in-flight reads when the owner changes between the acceptance and return cycles.

Reset
REQ-028 While reset is high, SHALL force the following:
- state = ARB and wait_cnt = 0.
- ram_en = ram_we = 0; ram_addr and ram_din = 0.
- rvalid0 = rvalid1 = 0 and all read tags cleared.
REQ-029 SHALL discard reads in flight when reset asserts mid-operation; no rvalid follows reset release for them.
REQ-030 SHALL gate gnt0/gnt1 low while reset is high.

Structure
REQ-031 SHALL place the state encoding (ARB, LOCK1) and requester ID constants (ID_CPU=0, ID_LDR=1) in shared package dmem_arb_pkg.
REQ-032 SHALL implement read return tracking in one sub-module, dmem_rd_tag_pipe: a two-stage valid+ID shift register with asynchronous clear.

Verification
REQ-033 Single CPU read: req0 with addr0=8'h10, RAM[16]=32'hDEADBEEF -> gnt0 in the same cycle; rvalid0 two edges later with rdata=32'hDEADBEEF.
REQ-034 Contention: req0 and req1 held high continuously, MAX_WAIT=4 -> CPU wins 4 cycles, loader wins the 5th, pattern repeats; no cycle has both gnt.
REQ-035 Burst lock: loader accepted with lock1=1 for 3 writes while req0 is held -> gnt0 low for those 3 cycles; after lock1=0 on the 3rd write, the CPU is granted on the next cycle.
REQ-036 Pipelined mixed reads: CPU, loader, CPU reads accepted on consecutive edges -> rvalid0, rvalid1, rvalid0 on consecutive cycles with the matching data.
REQ-037 Reset mid-read: reset pulsed one cycle after a read acceptance -> no rvalid afterwards; ram_en=0; state ARB.
REQ-038 Write then read at the same address: write 32'h12345678 to 8'h05, then read 8'h05 the next cycle -> rdata=32'h12345678.
